// File: rtl/serdes_pkg.sv
// Shared encodings for the serial sequencer and its shift register.
package serdes_pkg;

    // Word-level command op codes
    localparam logic [1:0] OpNop   = 2'd0;
    localparam logic [1:0] OpTx    = 2'd1;
    localparam logic [1:0] OpRx    = 2'd2;
    localparam logic [1:0] OpClear = 2'd3;

    // Universal shift register control codes
    localparam logic [2:0] CtrlHold   = 3'd0;
    localparam logic [2:0] CtrlClear  = 3'd1;
    localparam logic [2:0] CtrlLoad   = 3'd2;
    localparam logic [2:0] CtrlSinMsb = 3'd3;
    localparam logic [2:0] CtrlSinLsb = 3'd4;
    localparam logic [2:0] CtrlShl    = 3'd5;
    localparam logic [2:0] CtrlShr    = 3'd6;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

endpackage

// File: rtl/serdes_sequencer_if.sv
// Command/response handshake bundle between a word-level master and the sequencer.
interface serdes_sequencer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LW    = $clog2(WIDTH) + 1
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [LW-1:0]    cmd_len;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_aborted;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_len, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_aborted
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_len, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_aborted
    );
endinterface

// File: rtl/register.sv
// Universal shift register: hold, clear, parallel load, serial load at either end, shifts.
module register
    import serdes_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             async_nreset,
    input  logic [2:0]       ctrl,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    // Register update selected by ctrl; unknown codes hold
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            q <= '0;
        end else begin
            case (ctrl)
                CtrlClear:  q <= '0;
                CtrlLoad:   q <= d;
                CtrlSinMsb: q <= {sin, q[WIDTH-1:1]};
                CtrlSinLsb: q <= {q[WIDTH-2:0], sin};
                CtrlShl:    q <= {q[WIDTH-2:0], 1'b0};
                CtrlShr:    q <= {1'b0, q[WIDTH-1:1]};
                default:    q <= q;
            endcase
        end
    end

endmodule

// File: rtl/serdes_sequencer.sv
// Drives a universal shift register to run word-level TX/RX/CLEAR commands over a 1-bit link.
module serdes_sequencer
    import serdes_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 4,
    parameter int unsigned LW    = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               async_nreset,
    serdes_sequencer_if.slave  bus,
    input  logic               abort,
    input  logic               ser_in,
    output logic               ser_out,
    output logic               bit_strobe,
    output logic               busy
);

    localparam int unsigned    DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0]  DivLast  = DW'(DIV - 1);
    localparam logic [LW-1:0]  WidthLen = LW'(WIDTH);

    state_e           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [LW-1:0]    bit_q, bit_d;
    logic [LW-1:0]    len_q, len_d;
    logic             tx_q, tx_d;
    logic             aborted_q, aborted_d;
    logic [2:0]       ctrl;
    logic [WIDTH-1:0] q;
    logic [LW-1:0]    eff_len;
    logic             strobe;

    // A zero or oversized length means a full word
    assign eff_len = (bus.cmd_len == '0 || bus.cmd_len > WidthLen) ? WidthLen : bus.cmd_len;
    assign strobe  = (state_q == StShift) && (div_q == DivLast);

    // Sequencer state, counters and latched command attributes
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            state_q   <= StIdle;
            div_q     <= '0;
            bit_q     <= '0;
            len_q     <= '0;
            tx_q      <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            len_q     <= len_d;
            tx_q      <= tx_d;
            aborted_q <= aborted_d;
        end
    end

    // Next-state and register control decode
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        len_d     = len_q;
        tx_d      = tx_q;
        aborted_d = aborted_q;
        ctrl      = CtrlHold;
        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    div_d = '0;
                    bit_d = '0;
                    unique case (bus.cmd_op)
                        OpTx: begin
                            ctrl    = CtrlLoad;
                            len_d   = eff_len;
                            tx_d    = 1'b1;
                            state_d = StShift;
                        end
                        OpRx: begin
                            ctrl    = CtrlClear;
                            len_d   = eff_len;
                            tx_d    = 1'b0;
                            state_d = StShift;
                        end
                        OpClear: begin
                            ctrl    = CtrlClear;
                            tx_d    = 1'b0;
                            state_d = StDone;
                        end
                        default: state_d = StIdle;
                    endcase
                end
            end
            StShift: begin
                // Abort wins over a coinciding strobe: no shift in that cycle
                if (abort) begin
                    state_d   = StDone;
                    aborted_d = 1'b1;
                end else if (strobe) begin
                    div_d = '0;
                    bit_d = bit_q + 1'b1;
                    ctrl  = tx_q ? CtrlShl : CtrlSinLsb;
                    if (bit_q == len_q - 1'b1) begin
                        state_d = StDone;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.rsp_ready) begin
                    state_d   = StIdle;
                    aborted_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    register #(
        .WIDTH(WIDTH)
    ) u_register (
        .clk          (clk),
        .async_nreset (async_nreset),
        .ctrl         (ctrl),
        .d            (bus.cmd_data),
        .sin          (ser_in),
        .q            (q)
    );

    assign bus.cmd_ready   = (state_q == StIdle);
    assign busy            = (state_q != StIdle);
    assign bus.rsp_valid   = (state_q == StDone);
    assign bus.rsp_data    = (state_q == StDone) ? q : '0;
    assign bus.rsp_aborted = aborted_q;
    assign ser_out         = (state_q == StShift) && tx_q && q[WIDTH-1];
    assign bit_strobe      = strobe;

endmodule

// File: tb/tb_serdes_sequencer.sv
// Self-checking bench for serdes_sequencer: directed vector table, hand sequences, random commands.
module tb_serdes_sequencer;
    import serdes_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DIV   = 2;
    localparam int unsigned LW    = 4;

    logic clk = 1'b0;
    logic async_nreset = 1'b0;
    logic abort = 1'b0;
    logic ser_in = 1'b0;
    logic ser_out, bit_strobe, busy;

    serdes_sequencer_if #(.WIDTH(WIDTH), .LW(LW)) bus ();

    serdes_sequencer #(
        .WIDTH (WIDTH),
        .DIV   (DIV),
        .LW    (LW)
    ) dut (
        .clk          (clk),
        .async_nreset (async_nreset),
        .bus          (bus),
        .abort        (abort),
        .ser_in       (ser_in),
        .ser_out      (ser_out),
        .bit_strobe   (bit_strobe),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]    op;
        logic [7:0]    data;
        logic [LW-1:0] len;
        logic [7:0]    rx;
        int            abort_at;
        logic [7:0]    want;
        logic          want_ab;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, exp);
        end
    endtask

    // Reference: how many bits actually move, how long until the response, and the final word
    function automatic void model(input logic [1:0] op, input logic [7:0] data, input int len,
                                  input logic [7:0] rx, input int abort_at,
                                  output int shifts, output int cycles,
                                  output logic [7:0] exp, output logic ab);
        int n;
        n = (len == 0 || len > WIDTH) ? WIDTH : len;
        if (op == OpClear) begin
            shifts = 0;
            cycles = 1;
            exp    = 8'h00;
            ab     = 1'b0;
            return;
        end
        if (abort_at > 0 && abort_at <= n * DIV) begin
            shifts = (abort_at - 1) / DIV;
            cycles = abort_at + 1;
            ab     = 1'b1;
        end else begin
            shifts = n;
            cycles = n * DIV + 1;
            ab     = 1'b0;
        end
        if (op == OpTx) begin
            exp = data << shifts;
        end else begin
            exp = 8'h00;
            for (int i = 0; i < shifts; i++) exp = {exp[6:0], rx[n-1-i]};
        end
    endfunction

    task automatic run(input string name, input logic [1:0] op, input logic [7:0] data,
                       input logic [LW-1:0] len, input logic [7:0] rx, input int abort_at,
                       input logic [7:0] want, input logic want_ab);
        int shifts, cycles, n, cyc, k, seq_err, strobes, hold_err;
        logic [7:0] mexp;
        logic mab, exp_so;
        logic [7:0] held;
        model(op, data, int'(len), rx, abort_at, shifts, cycles, mexp, mab);
        n = (len == 0 || len > WIDTH) ? WIDTH : int'(len);
        @(negedge clk);
        for (int i = 0; i < 20 && !bus.cmd_ready; i++) @(negedge clk);
        check({name, " ready"}, bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        bus.cmd_len   = len;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        seq_err = 0;
        strobes = 0;
        k = 0;
        for (cyc = 1; cyc <= cycles + 3; cyc++) begin
            @(negedge clk);
            abort = 1'b0;
            if (bus.rsp_valid) break;
            exp_so = (op == OpTx) ? data[7 - (cyc - 1) / DIV] : 1'b0;
            if (ser_out !== exp_so || bit_strobe !== ((cyc % DIV) == 0) || busy !== 1'b1 ||
                bus.cmd_ready !== 1'b0) seq_err++;
            if (bit_strobe === 1'b1) strobes++;
            ser_in = (op == OpRx && bit_strobe === 1'b1 && k < n) ? rx[n-1-k] : 1'($urandom);
            if (bit_strobe === 1'b1) k++;
            if (cyc == abort_at) abort = 1'b1;
        end
        abort = 1'b0;
        check({name, " latency"}, cyc, cycles);
        check({name, " shift seq"}, seq_err, 0);
        check({name, " strobes"}, strobes, (cycles - 1) / DIV);
        check({name, " rsp_data"}, bus.rsp_data, want);
        check({name, " rsp_aborted"}, bus.rsp_aborted, want_ab);
        check({name, " done quiet"}, {ser_out, bit_strobe, bus.cmd_ready, busy}, 4'b0001);
        // Stall the response; stray commands and aborts must be ignored
        held = bus.rsp_data;
        hold_err = 0;
        for (int i = 0; i < 5; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 2'($urandom);
            bus.cmd_data  = 8'($urandom);
            abort         = 1'($urandom);
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== held || bus.cmd_ready !== 1'b0 ||
                bus.rsp_aborted !== want_ab) hold_err++;
        end
        bus.cmd_valid = 1'b0;
        abort         = 1'b0;
        check({name, " hold"}, hold_err, 0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({name, " idle"}, {busy, bus.cmd_ready, bus.rsp_valid, bus.rsp_aborted}, 4'b0100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int shifts, cycles, cyc, abort_at;
        logic [7:0] mexp, data, rx;
        logic mab;
        logic [1:0] op;
        logic [LW-1:0] len;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OpNop;
        bus.cmd_data  = '0;
        bus.cmd_len   = '0;
        bus.rsp_ready = 1'b0;

        vecs[0] = '{OpTx,    8'hA5, 4'd8, 8'h00, 0, 8'h00, 1'b0};
        vecs[1] = '{OpRx,    8'h00, 4'd4, 8'h0B, 0, 8'h0B, 1'b0};
        vecs[2] = '{OpTx,    8'hFF, 4'd0, 8'h00, 0, 8'h00, 1'b0};
        vecs[3] = '{OpTx,    8'hFF, 4'd9, 8'h00, 0, 8'h00, 1'b0};
        vecs[4] = '{OpTx,    8'h80, 4'd8, 8'h00, 6, 8'h00, 1'b1};
        vecs[5] = '{OpTx,    8'h3C, 4'd3, 8'h00, 0, 8'hE0, 1'b0};
        vecs[6] = '{OpClear, 8'h00, 4'd0, 8'h00, 0, 8'h00, 1'b0};
        vecs[7] = '{OpRx,    8'h00, 4'd8, 8'h96, 0, 8'h96, 1'b0};
        vecs[8] = '{OpRx,    8'h00, 4'd8, 8'hFF, 7, 8'h07, 1'b1};
        vecs[9] = '{OpTx,    8'h5A, 4'd8, 8'h00, 5, 8'h68, 1'b1};

        #2;
        check("reset outs", {ser_out, bit_strobe, busy, bus.rsp_valid, bus.rsp_aborted,
                             bus.cmd_ready}, 6'b000001);
        check("reset rsp_data", bus.rsp_data, 8'h00);
        @(negedge clk);
        async_nreset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].len, vecs[i].rx,
                vecs[i].abort_at, vecs[i].want, vecs[i].want_ab);
        end

        // NOP is accepted and produces nothing
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OpNop;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("nop", {busy, bus.rsp_valid, bus.cmd_ready}, 3'b001);

        // rsp_ready already high: response lasts exactly one DONE cycle
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OpTx;
        bus.cmd_data  = 8'hC3;
        bus.cmd_len   = 4'd2;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        for (cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
        end
        check("early latency", cyc, 5);
        check("early rsp_data", bus.rsp_data, 8'h0C);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("early idle", {busy, bus.rsp_valid, bus.cmd_ready}, 3'b001);

        // Reset in the middle of a receive
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OpRx;
        bus.cmd_len   = 4'd8;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        ser_in = 1'b1;
        repeat (7) @(negedge clk);
        check("midrx busy", busy, 1);
        #2 async_nreset = 1'b0;
        #1;
        check("midrx reset outs", {ser_out, bit_strobe, busy, bus.rsp_valid, bus.rsp_aborted,
                                   bus.cmd_ready}, 6'b000001);
        check("midrx reset data", bus.rsp_data, 8'h00);
        @(negedge clk);
        async_nreset = 1'b1;
        run("post reset clear", OpClear, 8'h00, 4'd0, 8'h00, 0, 8'h00, 1'b0);

        // Random commands against the reference model
        for (int i = 0; i < 40; i++) begin
            op       = ($urandom_range(0, 9) == 0) ? OpClear :
                       (($urandom_range(0, 1) == 0) ? OpTx : OpRx);
            data     = 8'($urandom);
            rx       = 8'($urandom);
            len      = LW'($urandom_range(0, 12));
            abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : 0;
            model(op, data, int'(len), rx, abort_at, shifts, cycles, mexp, mab);
            run($sformatf("rnd%0d", i), op, data, len, rx, abort_at, mexp, mab);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
